// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_t;

  localparam int PERF_CNT_W    = 32;
  localparam int HAZ_FLUSH_MAX = 7;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Fetch/decode hazard controller: load-use bubbles, redirect flush, memory freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// RUN   | normal issue; load-use and redirect detection active
// FLUSH | squashing fetch/decode after a taken redirect, fcnt cycles left
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex,
  input  logic                  rfile_we_ex,
  input  logic                  memory_re_ex,
  input  logic                  pc_we_ex,
  input  logic                  dmem_busy,
  output logic                  stall_if,
  output logic                  flush_if,
  output logic                  stall_id,
  output logic                  invalid_id
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam int                FCNT_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > HAZ_FLUSH_MAX) begin : g_bad_flush_cycles
    $error("hazard_unit: FLUSH_CYCLES out of range 1..7");
  end

  hazard_state_t     state, state_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              lu;

  assign lu = memory_re_ex && rfile_we_ex && (rd_addr_ex != '0) &&
              (((rd_addr_ex == rs1_addr_id) && use_rs1_id) ||
               ((rd_addr_ex == rs2_addr_id) && use_rs2_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fcnt_nxt   = fcnt;
    stall_if   = 1'b0;
    flush_if   = 1'b0;
    stall_id   = 1'b0;
    invalid_id = 1'b0;
    if (rst) begin
      flush_if   = 1'b1;
      invalid_id = 1'b1;
    end else if (dmem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (state == FLUSH) begin
      // Bubbles in flight carry pc_we=0, so a redirect seen here is stale.
      flush_if   = 1'b1;
      invalid_id = 1'b1;
      if (fcnt <= FCNT_ONE) begin
        fcnt_nxt  = '0;
        state_nxt = RUN;
      end else begin
        fcnt_nxt = fcnt - 1'b1;
      end
    end else if (pc_we_ex) begin
      flush_if   = 1'b1;
      invalid_id = 1'b1;
      fcnt_nxt   = FCNT_LOAD;
      state_nxt  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (lu) begin
      stall_if   = 1'b1;
      invalid_id = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic redirect_acc;
  logic bubble;

  // Only the accepted-redirect branch raises flush_if in RUN outside reset,
  // and only the load-use branch raises stall_if together with invalid_id.
  assign redirect_acc = !rst && flush_if && (state == RUN);
  assign bubble       = stall_if && invalid_id;

  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_id),
    .clr   (perf_clr),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble),
    .clr   (perf_clr),
    .count (bubble_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_acc),
    .clr   (perf_clr),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with FLUSH_CYCLES=2 and FLUSH_CYCLES=1 side by side.
// Performance-counter checks are compiled when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr_id, rs2_addr_id, rd_addr_ex;
  logic       use_rs1_id, use_rs2_id, rfile_we_ex, memory_re_ex, pc_we_ex, dmem_busy;
  logic       stall_if, flush_if, stall_id, invalid_id;
  logic       stall_if1, flush_if1, stall_id1, invalid_id1;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic                  perf_clr;
  logic [PERF_CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [PERF_CNT_W-1:0] stall_cnt1, bubble_cnt1, flush_cnt1;
  logic                  sc_inc, sc_clr;
  logic [2:0]            sc_count;
`endif

  always #5 clk = ~clk;

  hazard_unit #(.FLUSH_CYCLES(2), .REG_ADDR_W(5)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_addr_id  (rs1_addr_id),
    .rs2_addr_id  (rs2_addr_id),
    .use_rs1_id   (use_rs1_id),
    .use_rs2_id   (use_rs2_id),
    .rd_addr_ex   (rd_addr_ex),
    .rfile_we_ex  (rfile_we_ex),
    .memory_re_ex (memory_re_ex),
    .pc_we_ex     (pc_we_ex),
    .dmem_busy    (dmem_busy),
    .stall_if     (stall_if),
    .flush_if     (flush_if),
    .stall_id     (stall_id),
    .invalid_id   (invalid_id)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  hazard_unit #(.FLUSH_CYCLES(1), .REG_ADDR_W(5)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .rs1_addr_id  (rs1_addr_id),
    .rs2_addr_id  (rs2_addr_id),
    .use_rs1_id   (use_rs1_id),
    .use_rs2_id   (use_rs2_id),
    .rd_addr_ex   (rd_addr_ex),
    .rfile_we_ex  (rfile_we_ex),
    .memory_re_ex (memory_re_ex),
    .pc_we_ex     (pc_we_ex),
    .dmem_busy    (dmem_busy),
    .stall_if     (stall_if1),
    .flush_if     (flush_if1),
    .stall_id     (stall_id1),
    .invalid_id   (invalid_id1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cnt    (stall_cnt1),
    .bubble_cnt   (bubble_cnt1),
    .flush_cnt    (flush_cnt1)
`endif
  );

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .count (sc_count)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected vectors are {stall_if, flush_if, stall_id, invalid_id}.
  task automatic step(input string tag, input logic [3:0] e2, input logic [3:0] e1);
    #2;
    check({tag, "/fc2"}, 32'({stall_if, flush_if, stall_id, invalid_id}), 32'(e2));
    check({tag, "/fc1"}, 32'({stall_if1, flush_if1, stall_id1, invalid_id1}), 32'(e1));
    tick();
  endtask

  task automatic set_in(input logic re, input logic we, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic pcwe, input logic busy);
    memory_re_ex = re;
    rfile_we_ex  = we;
    rd_addr_ex   = rd;
    rs1_addr_id  = rs1;
    use_rs1_id   = u1;
    rs2_addr_id  = rs2;
    use_rs2_id   = u2;
    pc_we_ex     = pcwe;
    dmem_busy    = busy;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1'b0;
    sc_inc   = 1'b0;
    sc_clr   = 1'b0;
`endif
    tick();
    step("reset_busy", 4'b0101, 4'b0101);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 4'b0101, 4'b0101);
    rst = 1'b0;
    step("idle", 4'b0000, 4'b0000);

    set_in(1, 1, 5, 3, 1, 5, 1, 0, 0);
    step("lu_rs2", 4'b1001, 4'b1001);
    set_in(0, 1, 5, 3, 1, 5, 1, 0, 0);
    step("lu_cleared", 4'b0000, 4'b0000);
    set_in(1, 1, 0, 0, 1, 0, 1, 0, 0);
    step("lu_x0", 4'b0000, 4'b0000);
    set_in(1, 1, 5, 3, 1, 5, 0, 0, 0);
    step("lu_no_use", 4'b0000, 4'b0000);
    set_in(1, 1, 7, 7, 1, 2, 1, 0, 0);
    step("lu_rs1", 4'b1001, 4'b1001);
    set_in(1, 0, 7, 7, 1, 2, 1, 0, 0);
    step("lu_no_we", 4'b0000, 4'b0000);

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("redir_c0", 4'b0101, 4'b0101);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("redir_c1", 4'b0101, 4'b0000);
    step("redir_done", 4'b0000, 4'b0000);

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("busy_redir_c0", 4'b0101, 4'b0101);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("busy_1", 4'b1010, 4'b1010);
    step("busy_2", 4'b1010, 4'b1010);
    step("busy_3", 4'b1010, 4'b1010);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("busy_tail", 4'b0101, 4'b0000);
    step("busy_done", 4'b0000, 4'b0000);

    set_in(1, 1, 4, 4, 1, 0, 0, 1, 0);
    step("redir_lu", 4'b0101, 4'b0101);
    set_in(1, 1, 4, 4, 1, 0, 0, 0, 0);
    step("redir_lu_c1", 4'b0101, 4'b1001);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("redir_lu_done", 4'b0000, 4'b0000);

    set_in(1, 1, 6, 6, 1, 0, 0, 0, 1);
    step("busy_over_lu", 4'b1010, 4'b1010);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("busy_over_redir", 4'b1010, 4'b1010);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("redir_dropped", 4'b0000, 4'b0000);

    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rst_mid_c0", 4'b0101, 4'b0101);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rst_mid", 4'b0101, 4'b0101);
    rst = 1'b0;
    set_in(1, 1, 9, 9, 1, 0, 0, 0, 0);
    step("rst_then_run", 4'b1001, 4'b1001);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_then_idle", 4'b0000, 4'b0000);

`ifdef HAZARD_PERF_CNT_EN
    // Clear together with a bubble must leave zero.
    perf_clr = 1'b1;
    set_in(1, 1, 5, 5, 1, 0, 0, 0, 0);
    step("pc_clr_lu", 4'b1001, 4'b1001);
    perf_clr = 1'b0;
    #2;
    check("bubble_after_clr", bubble_cnt, 32'd0);
    check("stall_after_clr", stall_cnt, 32'd0);
    check("flush_after_clr", flush_cnt, 32'd0);
    step("pc_lu_a", 4'b1001, 4'b1001);
    step("pc_lu_b", 4'b1001, 4'b1001);
    set_in(1, 1, 5, 5, 1, 0, 0, 1, 0);
    step("pc_redir_lu", 4'b0101, 4'b0101);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("pc_busy_a", 4'b1010, 4'b1010);
    step("pc_busy_b", 4'b1010, 4'b1010);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pc_flush_tail", 4'b0101, 4'b0000);
    #2;
    check("bubble_cnt", bubble_cnt, 32'd2);
    check("stall_cnt", stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
    check("flush_cnt_fc1", flush_cnt1, 32'd1);
    sc_inc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2;
    check("sat_hold", 32'(sc_count), 32'd7);
    sc_clr = 1'b1;
    tick();
    #2;
    check("sat_clr_wins", 32'(sc_count), 32'd0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
